spi_txn_arbiter: RTL and testbench

SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

---
 rtl/spi_txn_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// -----------------------------------------------------------------------------
// spi_txn_arbiter
//
// Shares one SPI master between three requesters. A round-robin pick is made
// in IDLE; the winner's chip select, rw code, SPI mode and write byte are
// latched. The FSM then walks SETUP -> XFER -> GAP -> IDLE. A transfer ends
// on m_done, which gives an ack, or on timeout, which gives an err. A winner
// whose chip select is 00 is refused with an err and goes straight to GAP.
//
// Handshake: req[i] is a level request. It stays high until the arbiter
// answers with a one-cycle ack[i] or err[i] pulse. gnt[i] is high while
// requester i owns the master. Toward the master, m_start is a one-cycle
// launch pulse and m_done is a one-cycle completion pulse. m_done is only
// looked at in XFER.
//
// Parameters
//   GAP_CYCLES : idle cycles with m_cs=00 between transactions (1..15)
//   TIMEOUT    : XFER cycles allowed before giving up on m_done (2..255)
//
// Ports
//   clk, rst_n                  : clock, async active-low reset
//   req[2:0]                    : per-requester request level
//   req_cs/req_rw/req_mode[5:0] : 2 bits per requester
//   req_wdata[23:0]             : byte per requester, requester i at [8i+7:8i]
//   gnt/ack/err[2:0]            : one-hot grant, completion pulse, error pulse
//   rdata[7:0]                  : byte from the last completed transfer
//   busy                        : high whenever the FSM is not IDLE
//   m_cs/m_rw/m_mode, m_wdata   : fields of the granted transaction, to master
//   m_start                     : launch pulse, first XFER cycle only
//   m_done, m_rdata             : master completion pulse and received byte
//   dbg_state[1:0]              : FSM state (0 IDLE, 1 SETUP, 2 XFER, 3 GAP)
// -----------------------------------------------------------------------------
module spi_txn_arbiter #(
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [5:0]  req_cs,
    input  logic [5:0]  req_rw,
    input  logic [5:0]  req_mode,
    input  logic [23:0] req_wdata,
    output logic [2:0]  gnt,
    output logic [2:0]  ack,
    output logic [2:0]  err,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic [1:0]  m_cs,
    output logic [1:0]  m_rw,
    output logic [1:0]  m_mode,
    output logic [7:0]  m_wdata,
    output logic        m_start,
    input  logic        m_done,
    input  logic [7:0]  m_rdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [7:0] XFER_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  last_q, last_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [2:0]  ack_q, ack_d;
    logic [2:0]  err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [1:0]  cs_q, cs_d;
    logic [1:0]  rw_q, rw_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        start_q, start_d;
    logic [7:0]  xfer_cnt_q, xfer_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;

    // Round-robin winner: look at last+1, last+2, last+3 (mod 3) in order.
    logic [1:0]  win_idx;
    logic [2:0]  win_onehot;
    logic [1:0]  win_cs, win_rw, win_mode;
    logic [7:0]  win_wdata;
    logic [2:0]  rr_sum;
    logic        rr_found;

    always_comb begin
        win_idx  = last_q;
        rr_found = 1'b0;
        rr_sum   = 3'd0;
        for (int k = 1; k <= 3; k++) begin
            rr_sum = {1'b0, last_q} + 3'(k);
            if (rr_sum >= 3'd3) begin
                rr_sum = rr_sum - 3'd3;
            end
            if (!rr_found && req[rr_sum[1:0]]) begin
                rr_found = 1'b1;
                win_idx  = rr_sum[1:0];
            end
        end
        win_onehot = 3'b001 << win_idx;
    end

    always_comb begin
        case (win_idx)
            2'd0: begin
                win_cs    = req_cs[1:0];
                win_rw    = req_rw[1:0];
                win_mode  = req_mode[1:0];
                win_wdata = req_wdata[7:0];
            end
            2'd1: begin
                win_cs    = req_cs[3:2];
                win_rw    = req_rw[3:2];
                win_mode  = req_mode[3:2];
                win_wdata = req_wdata[15:8];
            end
            default: begin
                win_cs    = req_cs[5:4];
                win_rw    = req_rw[5:4];
                win_mode  = req_mode[5:4];
                win_wdata = req_wdata[23:16];
            end
        endcase
    end

    // State register: every flop of the block lives here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_q     <= 2'd2;
            gnt_q      <= 3'b000;
            ack_q      <= 3'b000;
            err_q      <= 3'b000;
            rdata_q    <= 8'h00;
            cs_q       <= 2'b00;
            rw_q       <= 2'b00;
            mode_q     <= 2'b00;
            wdata_q    <= 8'h00;
            start_q    <= 1'b0;
            xfer_cnt_q <= 8'd0;
            gap_cnt_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            cs_q       <= cs_d;
            rw_q       <= rw_d;
            mode_q     <= mode_d;
            wdata_q    <= wdata_d;
            start_q    <= start_d;
            xfer_cnt_q <= xfer_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // Next-state logic. ack/err/start are pulses and default to zero.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        ack_d      = 3'b000;
        err_d      = 3'b000;
        rdata_d    = rdata_q;
        cs_d       = cs_q;
        rw_d       = rw_q;
        mode_d     = mode_q;
        wdata_d    = wdata_q;
        start_d    = 1'b0;
        xfer_cnt_d = xfer_cnt_q;
        gap_cnt_d  = gap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    last_d = win_idx;
                    if (win_cs == 2'b00) begin
                        // Illegal select: refuse without ever touching the bus.
                        err_d     = win_onehot;
                        gap_cnt_d = 4'd0;
                        state_d   = ST_GAP;
                    end else begin
                        gnt_d   = win_onehot;
                        cs_d    = win_cs;
                        rw_d    = win_rw;
                        mode_d  = win_mode;
                        wdata_d = win_wdata;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                xfer_cnt_d = 8'd0;
                start_d    = 1'b1;
                state_d    = ST_XFER;
            end
            ST_XFER: begin
                // m_done is checked first so it wins over a timeout in the same cycle.
                if (m_done) begin
                    rdata_d   = m_rdata;
                    ack_d     = gnt_q;
                    gnt_d     = 3'b000;
                    gap_cnt_d = 4'd0;
                    state_d   = ST_GAP;
                end else if (xfer_cnt_q == XFER_LAST) begin
                    err_d     = gnt_q;
                    gnt_d     = 3'b000;
                    gap_cnt_d = 4'd0;
                    state_d   = ST_GAP;
                end else begin
                    xfer_cnt_d = xfer_cnt_q + 8'd1;
                end
            end
            default: begin  // ST_GAP
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
        endcase
    end

    // Output logic.
    always_comb begin
        gnt       = gnt_q;
        ack       = ack_q;
        err       = err_q;
        rdata     = rdata_q;
        busy      = (state_q != ST_IDLE);
        m_cs      = ((state_q == ST_SETUP) || (state_q == ST_XFER)) ? cs_q : 2'b00;
        m_rw      = rw_q;
        m_mode    = mode_q;
        m_wdata   = wdata_q;
        m_start   = start_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_txn_arbiter
//
// Directed bench for spi_txn_arbiter with the default parameters
// (GAP_CYCLES=2, TIMEOUT=64). Inputs change and outputs are sampled on the
// falling edge, and the design acts on the rising edge. Expected values are
// worked out by hand from the arbiter's timing:
//   edge k samples req -> SETUP (gnt, m_cs valid); edge k+1 -> XFER (m_start);
//   m_done in an XFER cycle -> ack visible the next cycle; GAP lasts 2 cycles.
// -----------------------------------------------------------------------------
module tb_spi_txn_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [5:0]  req_cs;
  logic [5:0]  req_rw;
  logic [5:0]  req_mode;
  logic [23:0] req_wdata;
  logic [2:0]  gnt;
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [7:0]  rdata;
  logic        busy;
  logic [1:0]  m_cs;
  logic [1:0]  m_rw;
  logic [1:0]  m_mode;
  logic [7:0]  m_wdata;
  logic        m_start;
  logic        m_done;
  logic [7:0]  m_rdata;
  logic [1:0]  dbg_state;

  int n_vec  = 0;
  int n_miss = 0;
  int start_cnt = 0;
  int viol_cnt  = 0;
  logic [1:0] exp_q[$];

  spi_txn_arbiter #(.GAP_CYCLES(2), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_cs(req_cs), .req_rw(req_rw),
    .req_mode(req_mode), .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .err(err),
    .rdata(rdata), .busy(busy), .m_cs(m_cs), .m_rw(m_rw), .m_mode(m_mode),
    .m_wdata(m_wdata), .m_start(m_start), .m_done(m_done), .m_rdata(m_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (!$onehot0(gnt) || !$onehot0(ack) || !$onehot0(err) || ((|ack) && (|err)))
        viol_cnt++;
      if (m_start) start_cnt++;
    end
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req    = 3'b000;
    m_done = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input string tag);
    int n = 0;
    while (gnt == 3'b000 && n < 10) begin
      tick();
      n++;
    end
    check_eq({tag, "_gnt_seen"}, 32'(gnt != 3'b000), 32'd1);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!m_start && n < 10) begin
      tick();
      n++;
    end
    check_eq({tag, "_start_seen"}, 32'(m_start), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int err_at;
    int starts_before;
    int early_err;
    logic [2:0] err_seen;
    logic [2:0] ack_at_err;
    logic [7:0] rdata_at_err;
    logic [1:0] got_idx;

    rst_n = 1'b0; req = 3'b000; req_cs = 6'b0; req_rw = 6'b0; req_mode = 6'b0;
    req_wdata = 24'h0; m_done = 1'b0; m_rdata = 8'h00;
    repeat (2) tick();

    // Reset state
    check_eq("rst_gnt",   32'(gnt),   32'h0);
    check_eq("rst_busy",  32'(busy),  32'h0);
    check_eq("rst_m_cs",  32'(m_cs),  32'h0);
    check_eq("rst_rdata", 32'(rdata), 32'h0);
    check_eq("rst_ackerr", 32'({ack, err, m_start}), 32'h0);
    check_eq("rst_fields", 32'({m_rw, m_mode, m_wdata}), 32'h0);
    check_eq("rst_state", 32'(dbg_state), 32'h0);
    rst_n = 1'b1;

    // ---- Single transaction ----
    req_cs[1:0] = 2'b01; req_mode[1:0] = 2'd2; req_rw[1:0] = 2'b10; req_wdata[7:0] = 8'hA5;
    req = 3'b001;
    tick();  // SETUP
    check_eq("single_gnt", 32'(gnt), 32'h1);
    check_eq("single_m_cs", 32'(m_cs), 32'h1);
    check_eq("single_setup_start", 32'(m_start), 32'h0);
    check_eq("single_fields", 32'({m_rw, m_mode, m_wdata}), 32'({2'b10, 2'd2, 8'hA5}));
    req_wdata[7:0] = 8'hFF; req_mode[1:0] = 2'd0;  // must not disturb latched fields
    tick();  // XFER cycle 0
    check_eq("single_start", 32'(m_start), 32'h1);
    check_eq("single_latched", 32'({m_mode, m_wdata}), 32'({2'd2, 8'hA5}));
    repeat (9) tick();  // XFER cycle 9
    check_eq("single_no_start", 32'(m_start), 32'h0);
    m_done = 1'b1; m_rdata = 8'h3C;
    tick();  // GAP cycle 0
    m_done = 1'b0;
    check_eq("single_ack", 32'(ack), 32'h1);
    check_eq("single_rdata", 32'(rdata), 32'h3C);
    check_eq("single_gnt_clr", 32'(gnt), 32'h0);
    check_eq("single_gap0_cs", 32'(m_cs), 32'h0);
    req = 3'b000;
    tick();  // GAP cycle 1
    check_eq("single_gap1", 32'({ack, m_cs, busy}), 32'({3'b000, 2'b00, 1'b1}));
    tick();  // IDLE
    check_eq("single_idle_busy", 32'(busy), 32'h0);
    check_eq("single_one_start", 32'(start_cnt), 32'd1);

    // ---- Contention: grant order 0,1,2,0,1,2 ----
    do_reset();
    req_cs = 6'b11_10_01;
    for (int i = 0; i < 6; i++) exp_q.push_back(2'(i % 3));
    req = 3'b111;
    for (int t = 0; t < 6; t++) begin
      wait_gnt("rr");
      got_idx = (gnt == 3'b010) ? 2'd1 : (gnt == 3'b100) ? 2'd2 : 2'd0;
      check_eq("rr_order", 32'(got_idx), 32'(exp_q.pop_front()));
      wait_start("rr");
      repeat (t + 1) tick();
      m_done = 1'b1; m_rdata = 8'(8'h10 + t);
      tick();
      m_done = 1'b0;
      check_eq("rr_ack", 32'(ack), 32'(3'b001 << got_idx));
    end
    req = 3'b000;
    repeat (4) tick();

    // ---- Timeout (rdata preset by a normal transfer) ----
    do_reset();
    req_cs[1:0] = 2'b01;
    req = 3'b001;
    wait_gnt("pre");
    wait_start("pre");
    m_done = 1'b1; m_rdata = 8'h5A;
    tick();
    m_done = 1'b0;
    req = 3'b000;
    repeat (4) tick();
    check_eq("pre_rdata", 32'(rdata), 32'h5A);
    req = 3'b001;
    wait_gnt("to");
    wait_start("to");  // XFER cycle 0 = start of the m_start cycle
    err_at = -1; err_seen = 3'b000; ack_at_err = 3'b000; rdata_at_err = 8'h00; early_err = 0;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (err != 3'b000 && err_at < 0) begin
        err_at = i; err_seen = err; ack_at_err = ack; rdata_at_err = rdata;
        req = 3'b000;
      end
      if (i < 64 && (err != 3'b000 || ack != 3'b000)) early_err++;
    end
    check_eq("to_err_cycle", 32'(err_at), 32'd64);
    check_eq("to_err_val", 32'(err_seen), 32'h1);
    check_eq("to_no_ack", 32'(ack_at_err), 32'h0);
    check_eq("to_rdata_kept", 32'(rdata_at_err), 32'h5A);
    check_eq("to_quiet_before", 32'(early_err), 32'd0);

    // ---- Boundary: m_done on XFER cycle TIMEOUT-1 ----
    req = 3'b001;
    wait_gnt("bnd");
    wait_start("bnd");
    repeat (63) tick();  // XFER cycle 63
    m_done = 1'b1; m_rdata = 8'hC3;
    tick();
    m_done = 1'b0;
    check_eq("bnd_ack_err", 32'({ack, err}), 32'({3'b001, 3'b000}));
    check_eq("bnd_rdata", 32'(rdata), 32'hC3);
    req = 3'b000;
    repeat (4) tick();

    // ---- Illegal chip select ----
    do_reset();
    req_cs = 6'b00_00_01;
    starts_before = start_cnt;
    req = 3'b010;
    tick();  // GAP cycle 0
    check_eq("ill_err", 32'(err), 32'h2);
    check_eq("ill_gnt_cs", 32'({gnt, m_cs}), 32'h0);
    req = 3'b011;
    wait_gnt("ill_next");
    check_eq("ill_no_start", 32'(start_cnt - starts_before), 32'd0);
    check_eq("ill_next_gnt", 32'(gnt), 32'h1);
    wait_start("ill_next");
    m_done = 1'b1; m_rdata = 8'h77;
    tick();
    m_done = 1'b0;
    check_eq("ill_next_ack", 32'(ack), 32'h1);
    req = 3'b000;
    repeat (4) tick();

    // ---- Reset mid-XFER ----
    req_cs = 6'b10_00_01;
    req = 3'b001;
    wait_gnt("rx");
    wait_start("rx");
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rx_async", 32'({gnt, m_cs, ack, err, busy}), 32'h0);
    req = 3'b000;
    tick();
    tick();
    rst_n = 1'b1;
    req = 3'b100;
    wait_gnt("rx_after");
    check_eq("rx_after_gnt", 32'({gnt, m_cs}), 32'({3'b100, 2'b10}));
    wait_start("rx_after");
    repeat (2) tick();
    m_done = 1'b1; m_rdata = 8'h9E;
    tick();
    m_done = 1'b0;
    check_eq("rx_after_ack", 32'({ack, rdata}), 32'({3'b100, 8'h9E}));
    req = 3'b000;
    repeat (4) tick();

    check_eq("onehot_invariants", 32'(viol_cnt), 32'd0);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
